// File: rtl/sevseg_scan_driver.sv
// Multiplexed common-anode 7-seg scanner with frame-aligned double buffering.
// Define SEVSEG_LZB_EN to blank leading zero digits (digit 0 always shown).
module sevseg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_vld_q, pend_vld_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic       tick, wrap;
  logic [3:0] nib;
  logic       dsel, lz;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h01;
      4'h1: hex7 = 7'h4F;
      4'h2: hex7 = 7'h12;
      4'h3: hex7 = 7'h06;
      4'h4: hex7 = 7'h4C;
      4'h5: hex7 = 7'h24;
      4'h6: hex7 = 7'h20;
      4'h7: hex7 = 7'h0F;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h0C;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h60;
      4'hC: hex7 = 7'h31;
      4'hD: hex7 = 7'h42;
      4'hE: hex7 = 7'h30;
      default: hex7 = 7'h38;
    endcase
  endfunction

  assign tick = en & (pcnt_q == PMAX);
  assign wrap = tick & (idx_q == IMAX);

  always_comb begin
    pcnt_d     = pcnt_q + 1'b1;
    idx_d      = idx_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    frame_d    = wrap;
    if (!en) begin
      pcnt_d = '0;
      idx_d  = '0;
    end else if (tick) begin
      pcnt_d = '0;
      idx_d  = wrap ? '0 : idx_q + 1'b1;
    end
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_mask;
      pend_vld_d = 1'b1;
    end
    // a same-cycle load bypasses the pending buffer
    if (wrap && (pend_vld_q || load)) begin
      disp_val_d = load ? value : pend_val_q;
      disp_dp_d  = load ? dp_mask : pend_dp_q;
      pend_vld_d = 1'b0;
    end
  end

`ifdef SEVSEG_LZB_EN
  logic allz;
`endif

  always_comb begin
    nib  = '0;
    dsel = 1'b0;
    lz   = 1'b0;
`ifdef SEVSEG_LZB_EN
    allz = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef SEVSEG_LZB_EN
      allz = allz & (disp_val_q[4*i +: 4] == 4'h0);
`endif
      if (idx_q == IW'(i)) begin
        nib  = disp_val_q[4*i +: 4];
        dsel = disp_dp_q[i];
`ifdef SEVSEG_LZB_EN
        lz   = allz && (i > 0);
`endif
      end
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = lz ? 7'h7F : hex7(nib);
      dp_d  = ~dsel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      an_q       <= '1;
      frame_q    <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Directed scoreboard bench for sevseg_scan_driver (DIGITS=4, REFRESH_DIV=4).
// Expected display cycles are queued with the stimulus and popped per clock.
module tb_sevseg_scan_driver;

  localparam int D = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  sevseg_scan_driver #(.DIGITS(D), .REFRESH_DIV(R)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .value(value), .dp_mask(dp_mask),
    .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int stepn = 0;

  function automatic logic [6:0] h7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h01; 4'h1: return 7'h4F;
      4'h2: return 7'h12; 4'h3: return 7'h06;
      4'h4: return 7'h4C; 4'h5: return 7'h24;
      4'h6: return 7'h20; 4'h7: return 7'h0F;
      4'h8: return 7'h00; 4'h9: return 7'h0C;
      4'hA: return 7'h08; 4'hB: return 7'h60;
      4'hC: return 7'h31; 4'hD: return 7'h42;
      4'hE: return 7'h30; default: return 7'h38;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
    logic [3:0] nb;
    nb = v[4*d +: 4];
`ifdef SEVSEG_LZB_EN
    if (d > 0 && (v >> (4*d)) == 16'h0) return 7'h7F;
`endif
    return h7(nb);
  endfunction

  // k = cycle index within a frame, 0..15; each digit lit for R cycles
  task automatic push_slice(input logic [15:0] v, input logic [3:0] m,
                            input int s, input int n);
    for (int k = s; k < s + n; k++) begin
      exp_t e;
      int d;
      d = k / R;
      e.an = ~(4'b0001 << d);
      e.seg = exp_seg(v, d);
      e.dp = ~m[d];
      e.fr = (k == D*R - 1);
      q.push_back(e);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input logic [3:0] m);
    push_slice(v, m, 0, D*R);
  endtask

  task automatic push_blank(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.an = 4'hF;
      e.seg = 7'h7F;
      e.dp = 1'b1;
      e.fr = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h",
             tag, stepn, obs, expv);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, ".an"}, 32'(an), 32'hF);
    chk({tag, ".seg"}, 32'(seg), 32'h7F);
    chk({tag, ".dp"}, 32'(dp), 32'h1);
    chk({tag, ".frame"}, 32'(frame), 32'h0);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    stepn++;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL underflow step=%0d observed=empty expected=entry", stepn);
    end else begin
      e = q.pop_front();
      chk("an", 32'(an), 32'(e.an));
      chk("seg", 32'(seg), 32'(e.seg));
      chk("dp", 32'(dp), 32'(e.dp));
      chk("frame", 32'(frame), 32'(e.fr));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    // reset state
    #12;
    chk_blank("reset");
    rst_n = 1'b1;
    en = 1'b1;

    // free scan of zeros, two frames
    push_frame(16'h0000, 4'h0);
    push_frame(16'h0000, 4'h0);
    run(32);

    // mid-frame load held until frame boundary
    push_frame(16'h0000, 4'h0);
    run(4);
    value = 16'h1A3F; dp_mask = 4'b0100; load = 1'b1;
    run(1);
    load = 1'b0;
    run(11);
    push_frame(16'h1A3F, 4'b0100);
    run(16);

    // last load wins, including one on the frame tick
    push_frame(16'h1A3F, 4'b0100);
    run(2);
    value = 16'h1111; dp_mask = 4'h0; load = 1'b1;
    run(1);
    load = 1'b0;
    run(2);
    value = 16'h2222; load = 1'b1;
    run(1);
    load = 1'b0;
    run(9);
    value = 16'h3333; load = 1'b1;
    run(1);
    load = 1'b0;
    push_frame(16'h3333, 4'h0);
    push_frame(16'h3333, 4'h0);
    run(32);

    // enable low mid-scan, load accepted while blanked
    push_slice(16'h3333, 4'h0, 0, 6);
    run(6);
    en = 1'b0;
    push_blank(10);
    run(3);
    value = 16'h4444; dp_mask = 4'b1000; load = 1'b1;
    run(1);
    load = 1'b0;
    run(6);
    en = 1'b1;
    push_frame(16'h3333, 4'h0);
    run(16);
    push_frame(16'h4444, 4'b1000);
    run(16);

    // async reset mid-digit with a pending load
    push_slice(16'h4444, 4'b1000, 0, 5);
    run(5);
    value = 16'h5555; dp_mask = 4'h0; load = 1'b1;
    push_slice(16'h4444, 4'b1000, 5, 2);
    run(1);
    load = 1'b0;
    run(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_blank("rst_async");
    @(posedge clk);
    #1;
    chk_blank("rst_hold");
    rst_n = 1'b1;
    push_frame(16'h0000, 4'h0);
    push_frame(16'h0000, 4'h0);
    run(32);

    // leading-zero pattern
    push_frame(16'h0000, 4'h0);
    value = 16'h0050; dp_mask = 4'h0; load = 1'b1;
    run(1);
    load = 1'b0;
    run(15);
    push_frame(16'h0050, 4'h0);
    run(16);

    chk("drain", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevseg_scan_driver.md
# sevseg_scan_driver

Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It sits between the datapath and the board display pins. It latches a packed hex value plus decimal-point mask, then cycles one active-low anode at a time at a programmable refresh rate. Each digit's nibble is decoded to active-low segments. Loads are double-buffered and committed only at frame boundaries, so the display never shows a torn value.

## Interface
- DIGITS, 4, number of digits scanned; legal 1..8
- REFRESH_DIV, 100000, clk cycles each digit stays lit; legal >= 2
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  scan enable; low blanks display and holds scan state at zero
- load  input  1  single-cycle strobe capturing value/dp_mask into pending buffer
- value  input  4*DIGITS  packed nibbles, digit 0 = value[3:0] (rightmost)
- dp_mask  input  DIGITS  1 = light decimal point of that digit
- seg  output  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-low, registered
- dp  output  1  decimal point, active-low, registered
- an  output  DIGITS  anode selects, active-low, one-hot-low when lit, registered
- frame  output  1  one-cycle pulse on the cycle the scan wraps from digit DIGITS-1 to 0

## Operation
- Prescaler pcnt (clog2(REFRESH_DIV) bits) counts 0..REFRESH_DIV-1 while en=1, then wraps; tick = en & (pcnt==REFRESH_DIV-1).
- Digit index idx (max(1,clog2(DIGITS)) bits) increments on tick and wraps DIGITS-1 -> 0; frame=1 on that wrap tick.
- Buffers: pend_val/pend_dp/pend_vld, disp_val/disp_dp.
  - load=1 writes pend_* and sets pend_vld.
  - Multiple loads before commit: last load wins.
- Commit occurs on a frame tick with pend_vld=1 (or load=1 that same cycle):
  - disp_* takes pend_* (or the incoming value/dp_mask if load=1 the same cycle);
  - pend_vld clears.
- Output registers, each cycle with en=1: an <= ~(1<<idx), seg <= decode(disp_val nibble idx), dp <= ~disp_dp[idx].
- Output registers with en=0: an, seg, dp all ones; pcnt=0; idx=0. Loads are still accepted into the pending buffer.
- Decode (7-bit hex of seg): 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F 8:00 9:0C A:08 b:60 C:31 d:42 E:30 F:38.
- No out-of-range or X handling beyond the 16 codes; every nibble value is defined.

## Timing
- Reset (async assert, any time, including mid-frame or mid-load) gives:
  - seg=7'h7F, dp=1, an all ones, frame=0;
  - pcnt=0, idx=0;
  - disp_val=0, disp_dp=0, pend_vld=0.
- First rising edge with en=1 after reset release drives an=~1 and seg=7'h01 (digit 0 shows "0").
- Outputs lag idx by exactly one cycle. A digit is lit for exactly REFRESH_DIV cycles. A full frame is DIGITS*REFRESH_DIV cycles.
- Load-to-display latency: from the load edge up to one full frame plus one cycle. Minimum is one cycle, when the load coincides with the frame tick.
- frame pulse is registered with the wrap edge. It is high for the one cycle after tick, when idx becomes 0.
- en falling blanks outputs on the next edge. en rising restarts scanning at digit 0 with pcnt=0.

## Configuration
- SEVSEG_LZB_EN defined: leading-zero blanking is enabled.
  - Any digit i>0 whose nibble and all higher nibbles of disp_val are zero drives seg=7'h7F.
  - Its anode is still asserted and its dp still honours disp_dp.
  - Digit 0 is never blanked.
- SEVSEG_LZB_EN undefined: every digit shows its decoded nibble, zeros included.

## Test plan
- Setup for all scenarios: DIGITS=4, REFRESH_DIV=4.
- Reset, en=1, no load -> an cycles E,D,B,7 every 4 cycles, seg=01 each digit; frame pulses every 16 cycles.
- load value=16'h1A3F, dp_mask=4'b0100 mid-frame -> display unchanged until next frame; then digits 0..3 show seg 38,06,08,4F, and dp=0 only while an=B.
- Two loads (16'h1111 then 16'h2222) in one frame; a further load of 16'h3333 on the frame-tick cycle -> next frame shows 3333, never 1111 or 2222.
- en=0 for 10 cycles mid-scan -> an=F, seg=7F next edge; on en=1, digit 0 is lit for a full 4 cycles.
- rst_n pulsed low mid-digit with pend_vld=1 -> outputs blank immediately; after release, display shows 0000 and pending value is discarded.
- With SEVSEG_LZB_EN, value=16'h0050 -> digits 3,2 seg=7F, digit 1 seg=24, digit 0 seg=01; without the macro, digits 3,2 seg=01.
